// File: rtl/usb_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : usb_disp_pkg
// Purpose  : Shared definitions for the USB receive dispatcher: FSM state
//            encoding, default address map constants and the length type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package usb_disp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REG   = 3'd1,
        ST_LEN_H = 3'd2,
        ST_LEN_L = 3'd3,
        ST_CCW   = 3'd4,
        ST_DROP  = 3'd5
    } state_t;

    localparam logic [7:0] CCW_BUF_ADDR_DEF = 8'h10;
    localparam logic [7:0] REG_ADDR_MAX_DEF = 8'h3F;
    localparam int         CCW_DEPTH_DEF    = 128;

    typedef logic [15:0] len_t;

endpackage : usb_disp_pkg
`default_nettype wire

// File: rtl/usb_disp_stats.sv
`default_nettype none
// ============================================================================
// Module   : usb_disp_stats
// Purpose  : Saturating frame statistics for the USB receive dispatcher.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            frame_good       - one-cycle pulse per accepted frame
//            frame_bad        - one-cycle pulse per rejected frame
//            frame_cnt[15:0]  - good-frame count, saturates at all-ones
//            err_cnt[7:0]     - error count, saturates at all-ones
// Revision : 1.0 - initial release
// ============================================================================
module usb_disp_stats
    import usb_disp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_good,
    input  logic        frame_bad,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 16'd0;
            err_cnt   <= 8'd0;
        end else begin
            if (frame_good && (frame_cnt != 16'hFFFF))
                frame_cnt <= frame_cnt + 16'd1;
            if (frame_bad && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule : usb_disp_stats
`default_nettype wire

// File: rtl/usb_rx_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_dispatcher
// Purpose  : Routes CRC-checked USB frames (one byte per cycle) either to a
//            bank of control registers or into the CCW buffer, based on the
//            address in byte 0. All outputs are registered.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            d[7:0], d_asserted     - frame byte and frame-wide valid
//            reg_wr/addr/data       - control-register write port
//            ccw_wr/addr/data       - CCW buffer write port
//            ccw_done, ccw_len      - payload commit pulse and latched length
//            frame_err              - rejected/malformed frame pulse
//            frame_cnt, err_cnt     - only when USB_RX_DISPATCHER_STATS_EN
// Options  : USB_RX_DISPATCHER_STATS_EN adds saturating frame statistics.
// Revision : 1.0 - initial release
// ============================================================================
module usb_rx_dispatcher
    import usb_disp_pkg::*;
#(
    parameter logic [7:0] CCW_BUF_ADDR = CCW_BUF_ADDR_DEF,
    parameter logic [7:0] REG_ADDR_MAX = REG_ADDR_MAX_DEF,
    parameter int         CCW_DEPTH    = CCW_DEPTH_DEF
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  d,
    input  logic        d_asserted,
    output logic        reg_wr,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_data,
    output logic        ccw_wr,
    output logic [6:0]  ccw_addr,
    output logic [7:0]  ccw_data,
    output logic        ccw_done,
    output logic [15:0] ccw_len,
`ifdef USB_RX_DISPATCHER_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
`endif
    output logic        frame_err
);

    localparam len_t DEPTH_LEN = len_t'(CCW_DEPTH);

    state_t      state, state_nxt;
    logic [7:0]  base, base_nxt;
    logic [7:0]  idx, idx_nxt;
    logic [7:0]  len_hi, len_hi_nxt;
    len_t        len, len_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        excess, excess_nxt;
    len_t        len_cand;
    len_t        cnt_wide;

    logic        reg_wr_nxt, ccw_wr_nxt, ccw_done_nxt, frame_err_nxt;
    logic [7:0]  reg_addr_nxt, reg_data_nxt, ccw_data_nxt;
    logic [6:0]  ccw_addr_nxt;
    logic [15:0] ccw_len_nxt;

    assign len_cand = {len_hi, d};
    assign cnt_wide = {8'd0, cnt};

    // A reset released while a frame is still streaming must not decode the
    // tail of that frame, so the FSM parks in DROP until the gap.
    always_ff @(posedge clk) begin
        if (rst)
            state <= d_asserted ? ST_DROP : ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        base_nxt      = base;
        idx_nxt       = idx;
        len_hi_nxt    = len_hi;
        len_nxt       = len;
        cnt_nxt       = cnt;
        excess_nxt    = excess;
        reg_wr_nxt    = 1'b0;
        reg_addr_nxt  = reg_addr;
        reg_data_nxt  = reg_data;
        ccw_wr_nxt    = 1'b0;
        ccw_addr_nxt  = ccw_addr;
        ccw_data_nxt  = ccw_data;
        ccw_done_nxt  = 1'b0;
        ccw_len_nxt   = ccw_len;
        frame_err_nxt = 1'b0;

        case (state)
            ST_IDLE: begin
                if (d_asserted) begin
                    // The CCW address lies inside the register range, so it
                    // has to be tested first.
                    if (d == CCW_BUF_ADDR) begin
                        state_nxt = ST_LEN_H;
                    end else if (d <= REG_ADDR_MAX) begin
                        state_nxt = ST_REG;
                        base_nxt  = d;
                        idx_nxt   = 8'd0;
                    end else begin
                        state_nxt     = ST_DROP;
                        frame_err_nxt = 1'b1;
                    end
                end
            end
            ST_REG: begin
                if (d_asserted) begin
                    reg_wr_nxt   = 1'b1;
                    reg_addr_nxt = base + idx;
                    reg_data_nxt = d;
                    idx_nxt      = idx + 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LEN_H: begin
                if (d_asserted) begin
                    len_hi_nxt = d;
                    state_nxt  = ST_LEN_L;
                end else begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_LEN_L: begin
                if (d_asserted) begin
                    if ((len_cand == '0) || (len_cand > DEPTH_LEN)) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_DROP;
                    end else begin
                        len_nxt    = len_cand;
                        cnt_nxt    = 8'd0;
                        excess_nxt = 1'b0;
                        state_nxt  = ST_CCW;
                    end
                end else begin
                    frame_err_nxt = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            ST_CCW: begin
                if (d_asserted) begin
                    if (cnt_wide < len) begin
                        ccw_wr_nxt   = 1'b1;
                        ccw_addr_nxt = cnt[6:0];
                        ccw_data_nxt = d;
                        cnt_nxt      = cnt + 8'd1;
                    end else begin
                        // Bytes beyond the declared length are discarded but
                        // remembered so the frame is rejected at its end.
                        excess_nxt = 1'b1;
                    end
                end else begin
                    if ((cnt_wide == len) && !excess) begin
                        ccw_done_nxt = 1'b1;
                        ccw_len_nxt  = len;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!d_asserted)
                    state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base      <= 8'd0;
            idx       <= 8'd0;
            len_hi    <= 8'd0;
            len       <= '0;
            cnt       <= 8'd0;
            excess    <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 8'd0;
            reg_data  <= 8'd0;
            ccw_wr    <= 1'b0;
            ccw_addr  <= 7'd0;
            ccw_data  <= 8'd0;
            ccw_done  <= 1'b0;
            ccw_len   <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            base      <= base_nxt;
            idx       <= idx_nxt;
            len_hi    <= len_hi_nxt;
            len       <= len_nxt;
            cnt       <= cnt_nxt;
            excess    <= excess_nxt;
            reg_wr    <= reg_wr_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_data  <= reg_data_nxt;
            ccw_wr    <= ccw_wr_nxt;
            ccw_addr  <= ccw_addr_nxt;
            ccw_data  <= ccw_data_nxt;
            ccw_done  <= ccw_done_nxt;
            ccw_len   <= ccw_len_nxt;
            frame_err <= frame_err_nxt;
        end
    end

`ifdef USB_RX_DISPATCHER_STATS_EN
    // A register frame is good whenever it ends cleanly; a CCW frame is good
    // exactly when it commits.
    logic frame_good;
    assign frame_good = ((state == ST_REG) && !d_asserted) || ccw_done_nxt;

    usb_disp_stats u_stats (
        .clk        (clk),
        .rst        (rst),
        .frame_good (frame_good),
        .frame_bad  (frame_err_nxt),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt)
    );
`endif

endmodule : usb_rx_dispatcher
`default_nettype wire

// File: tb/tb_usb_rx_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_rx_dispatcher
// Purpose  : Self-checking bench for usb_rx_dispatcher. Frames are decoded by
//            a frame-level reference model into an expected event queue; a
//            monitor pops and compares each strobe the DUT presents.
// Options  : USB_RX_DISPATCHER_STATS_EN also checks frame_cnt/err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_rx_dispatcher;

    localparam int K_REG  = 0;
    localparam int K_CCW  = 1;
    localparam int K_DONE = 2;
    localparam int K_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d;
    logic        d_asserted;
    logic        reg_wr;
    logic [7:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        ccw_wr;
    logic [6:0]  ccw_addr;
    logic [7:0]  ccw_data;
    logic        ccw_done;
    logic [15:0] ccw_len;
    logic        frame_err;
`ifdef USB_RX_DISPATCHER_STATS_EN
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
`endif

    usb_rx_dispatcher dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .d_asserted (d_asserted),
        .reg_wr     (reg_wr),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .ccw_wr     (ccw_wr),
        .ccw_addr   (ccw_addr),
        .ccw_data   (ccw_data),
        .ccw_done   (ccw_done),
        .ccw_len    (ccw_len),
`ifdef USB_RX_DISPATCHER_STATS_EN
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
`endif
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] len;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  frame_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_ccw_len = 16'd0;
    int          exp_frames = 0;
    int          exp_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void push_ev(input int k, input logic [7:0] a,
                                    input logic [7:0] dt, input logic [15:0] l);
        ev_t e;
        e.kind = k; e.addr = a; e.data = dt; e.len = l;
        exp_q.push_back(e);
    endfunction

    function automatic void push_err();
        push_ev(K_ERR, 8'd0, 8'd0, 16'd0);
        exp_errs++;
    endfunction

    // Frame-level reference: decides the whole outcome of a frame from its
    // byte list in one go.
    function automatic void model_frame();
        int          n;
        int          pay;
        int          lv;
        logic [7:0]  a;
        logic [15:0] l;
        n = frame_q.size();
        if (n == 0) return;
        a = frame_q[0];
        if (a == 8'h10) begin
            if (n < 3) begin
                push_err();
                return;
            end
            l  = {frame_q[1], frame_q[2]};
            lv = int'(l);
            if (lv == 0 || lv > 128) begin
                push_err();
                return;
            end
            pay = n - 3;
            for (int i = 0; i < pay && i < lv; i++)
                push_ev(K_CCW, 8'(i), frame_q[3 + i], 16'd0);
            if (pay == lv) begin
                push_ev(K_DONE, 8'd0, 8'd0, l);
                exp_frames++;
            end else begin
                push_err();
            end
        end else if (a <= 8'h3F) begin
            for (int i = 1; i < n; i++)
                push_ev(K_REG, 8'(int'(a) + i - 1), frame_q[i], 16'd0);
            exp_frames++;
        end else begin
            push_err();
        end
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    int   mon_n;
    int   mon_kind;
    ev_t  mon_e;
    always @(negedge clk) begin
        mon_n = int'(reg_wr) + int'(ccw_wr) + int'(ccw_done) + int'(frame_err);
        mon_kind = reg_wr ? K_REG : ccw_wr ? K_CCW : ccw_done ? K_DONE : K_ERR;
        if (mon_n > 1) begin
            check("single_strobe", 32'(mon_n), 32'd1);
        end else if (mon_n == 1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'(mon_kind), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 32'(mon_kind), 32'(mon_e.kind));
                if (mon_kind == mon_e.kind) begin
                    case (mon_kind)
                        K_REG: begin
                            check("reg_addr", 32'(reg_addr), 32'(mon_e.addr));
                            check("reg_data", 32'(reg_data), 32'(mon_e.data));
                        end
                        K_CCW: begin
                            check("ccw_addr", 32'(ccw_addr), 32'(mon_e.addr[6:0]));
                            check("ccw_data", 32'(ccw_data), 32'(mon_e.data));
                        end
                        K_DONE: begin
                            exp_ccw_len = mon_e.len;
                            check("ccw_len_done", 32'(ccw_len), 32'(exp_ccw_len));
                        end
                        default: begin
                            check("ccw_len_held", 32'(ccw_len), 32'(exp_ccw_len));
                        end
                    endcase
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] b);
        @(posedge clk);
        #1;
        d_asserted = v;
        d          = b;
    endtask

    task automatic send(input int gap);
        model_frame();
        foreach (frame_q[i]) drive(1'b1, frame_q[i]);
        repeat (gap) drive(1'b0, 8'($urandom));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
`ifdef USB_RX_DISPATCHER_STATS_EN
        check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("err_cnt", 32'(err_cnt), 32'(exp_errs));
`endif
    endtask

    task automatic gen_random();
        int kind;
        int len;
        int pay;
        kind = int'($urandom_range(0, 5));
        frame_q.delete();
        len = 0;
        pay = 0;
        case (kind)
            0: begin
                frame_q.push_back(8'($urandom_range(0, 63)));
                pay = int'($urandom_range(0, 5));
            end
            1: begin
                len = ($urandom_range(0, 7) == 0) ? 128 : int'($urandom_range(1, 8));
                pay = len;
            end
            2: begin
                len = int'($urandom_range(1, 8));
                pay = ($urandom_range(0, 1) == 1) ? len + int'($urandom_range(1, 2))
                                                  : int'($urandom_range(0, len - 1));
            end
            3: begin
                frame_q.push_back(8'($urandom_range(64, 255)));
                pay = int'($urandom_range(0, 4));
            end
            4: begin
                len = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(129, 65535));
                pay = int'($urandom_range(0, 3));
            end
            default: begin
                frame_q.push_back(8'h10);
                if ($urandom_range(0, 1) == 1) frame_q.push_back(8'($urandom));
            end
        endcase
        if (kind == 1 || kind == 2 || kind == 4) begin
            frame_q.push_back(8'h10);
            frame_q.push_back(8'(len >> 8));
            frame_q.push_back(8'(len));
        end
        repeat (pay) frame_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [7:0] pl[8];
        rst        = 1'b1;
        d_asserted = 1'b0;
        d          = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_reg_wr",    32'(reg_wr),    32'd0);
        check("rst_reg_addr",  32'(reg_addr),  32'd0);
        check("rst_reg_data",  32'(reg_data),  32'd0);
        check("rst_ccw_wr",    32'(ccw_wr),    32'd0);
        check("rst_ccw_addr",  32'(ccw_addr),  32'd0);
        check("rst_ccw_data",  32'(ccw_data),  32'd0);
        check("rst_ccw_done",  32'(ccw_done),  32'd0);
        check("rst_ccw_len",   32'(ccw_len),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);

        // Directed frames
        frame_q = '{8'h05, 8'hAA, 8'hBB, 8'hCC};             send(2);
        frame_q = '{8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33}; send(2);
        frame_q = '{8'h10, 8'h00, 8'h04, 8'h11, 8'h22};        send(2);
        frame_q = '{8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33}; send(2);
        frame_q = '{8'h80, 8'h01, 8'h02, 8'h03, 8'h04};        send(1);
        frame_q = '{8'h01, 8'h5A};                             send(2);
        frame_q = '{8'h10, 8'h00, 8'h81, 8'h01, 8'h02};        send(2);
        frame_q = '{8'h10, 8'h00, 8'h00, 8'h01};               send(2);
        frame_q = '{8'h3F, 8'h01, 8'h02};                      send(1);
        frame_q = '{8'h20};                                    send(1);
        frame_q = '{8'h10, 8'h00};                             send(1);
        wait_drain();

        // Randomized frames, back-to-back gaps included
        for (int f = 0; f < 80; f++) begin
            gen_random();
            send(int'($urandom_range(1, 3)));
        end
        wait_drain();

        // Reset in the middle of a CCW payload with the frame still streaming
        foreach (pl[i]) pl[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) push_ev(K_CCW, 8'(i), pl[i], 16'd0);
        drive(1'b1, 8'h10);
        drive(1'b1, 8'h00);
        drive(1'b1, 8'h08);
        for (int i = 0; i < 3; i++) drive(1'b1, pl[i]);
        @(posedge clk);
        #1;
        rst = 1'b1; d_asserted = 1'b1; d = pl[3];
        exp_ccw_len = 16'd0;
        exp_frames  = 0;
        exp_errs    = 0;
        drive(1'b1, pl[4]);
        @(posedge clk);
        #1;
        rst = 1'b0; d = pl[5];
        @(negedge clk);
        check("post_rst_ccw_len", 32'(ccw_len), 32'd0);
`ifdef USB_RX_DISPATCHER_STATS_EN
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("post_rst_err_cnt",   32'(err_cnt),   32'd0);
`endif
        drive(1'b1, pl[6]);
        drive(1'b1, pl[7]);
        drive(1'b0, 8'h00);
        drive(1'b0, 8'h00);
        wait_drain();

        frame_q = '{8'h10, 8'h00, 8'h02, 8'hDE, 8'hAD}; send(1);
        frame_q = '{8'h07, 8'h99};                     send(2);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_usb_rx_dispatcher
`default_nettype wire
